vram_read_streamer: RTL and testbench

//   Downstream consumer of the video RAM's synchronous read port.
//   - On a start pulse, walks read_addr over a contiguous window and

---
 rtl/vram_read_streamer.sv | 128 ++++++++++++
 tb/tb_vram_read_streamer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_read_streamer.sv
// Streams a contiguous window of video RAM out of its synchronous read port
// as a valid/ready word stream, buffered through a 2-entry output FIFO.
module vram_read_streamer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  iss;
    logic                  iss_last;
    logic                  pend;
    logic                  pend_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  next_pend;
    logic [1:0]            next_count;

    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];

    // iss: address on read_addr not yet sampled by the RAM.
    // pend: q holds a sampled word not yet pushed; q stays stable for as long
    // as read_addr is not changed, so a pending word can wait for FIFO room.
    // A new address is only issued when the word it would displace from q is
    // certain to be pushed on the next edge, so nothing is ever dropped.
    always_comb begin
        pop        = out_valid & out_ready;
        push       = pend & ((count != 2'd2) | pop);
        next_count = count + 2'(push) - 2'(pop);
        next_pend  = iss | (pend & ~push);
        issue      = (state == RUN) & (~next_pend | (next_count <= 2'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_cnt     <= '0;
            remaining    <= '0;
            read_addr    <= '0;
            iss          <= 1'b0;
            iss_last     <= 1'b0;
            pend         <= 1'b0;
            pend_last    <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done  <= 1'b0;
            count <= next_count;
            pend  <= next_pend;
            iss   <= issue;
            iss_last <= issue & (remaining == (ADDR_WIDTH+1)'(1));
            if (iss)
                pend_last <= iss_last;
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push) begin
                fifo_data[wr_ptr] <= q;
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (issue) begin
                read_addr <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
                remaining <= remaining - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_cnt  <= base_addr;
                            remaining <= length;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && remaining == (ADDR_WIDTH+1)'(1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && fifo_last[rd_ptr]) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_read_streamer.sv
// Directed bench for vram_read_streamer with a behavioural synchronous RAM
// holding RAM[i] = i, so every expected word equals its address.
module tb_vram_read_streamer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic [7:0] read_addr;
    logic [7:0] q;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];

    int vectors    = 0;
    int miscompares = 0;

    vram_read_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .read_addr (read_addr),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) q <= mem[read_addr];

    // Called at a negedge; start is sampled on the next posedge (edge 0) and
    // the task returns at the negedge following edge 0.
    task automatic pulse_start(input logic [7:0] b, input logic [8:0] len);
        start     = 1'b1;
        base_addr = b;
        length    = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({read_addr, out_valid, out_last, busy, done} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: got addr=%h valid=%b last=%b busy=%b done=%b, want all 0",
                     read_addr, out_valid, out_last, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        pulse_start(8'h10, 9'd4);
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy: got busy=%b valid=%b, want busy=1 valid=0", busy, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (read_addr !== 8'h10 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_addr: got addr=%h valid=%b, want addr=10 valid=0", read_addr, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency: got valid=%b after edge 2, want 0", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + k) || out_last !== (k == 3) || done !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_word%0d: got valid=%b data=%h last=%b done=%b, want valid=1 data=%h last=%b done=0",
                         k, out_valid, out_data, out_last, done, 8'(8'h10 + k), (k == 3));
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: got done=%b busy=%b valid=%b, want done=1 busy=0 valid=0", done, busy, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_addr [4];
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
        out_ready = 1'b1;
        pulse_start(8'hFE, 9'd4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                vectors++;
                if (read_addr !== exp_addr[k-1]) begin
                    miscompares++;
                    $display("FAIL wrap_addr%0d: got %h, want %h", k - 1, read_addr, exp_addr[k-1]);
                end
            end
            if (k >= 3 && k <= 6) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp_addr[k-3] || out_last !== (k == 6)) begin
                    miscompares++;
                    $display("FAIL wrap_word%0d: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                             k - 3, out_valid, out_data, out_last, exp_addr[k-3], (k == 6));
                end
            end
            if (k == 7) begin
                vectors++;
                if (done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wrap_done: got done=%b, want 1", done);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero_len;
        int done_cnt = 0;
        logic any_bad = 1'b0;
        out_ready = 1'b1;
        pulse_start(8'h33, 9'd0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: got done=%b busy=%b valid=%b, want done=1 busy=0 valid=0", done, busy, out_valid);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy || out_valid) any_bad = 1'b1;
        end
        vectors++;
        if (done_cnt != 0 || any_bad) begin
            miscompares++;
            $display("FAIL zero_quiet: got extra done=%0d busy_or_valid=%b, want 0 and 0", done_cnt, any_bad);
        end
    endtask

    task automatic test_stall;
        logic [31:0] pat = 32'b1011_0010_1110_0101_1001_1100_0111_0100;
        int          idx = 0;
        int          done_cnt = 0;
        logic        prev_stall = 1'b0;
        logic [7:0]  prev_data = '0;
        logic        prev_last = 1'b0;
        out_ready = 1'b1;
        pulse_start(8'h40, 9'd8);
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (done) done_cnt++;
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            out_ready = pat[cyc % 32];
            if (out_valid && out_ready) begin
                vectors++;
                if (idx >= 8 || out_data !== 8'(8'h40 + idx) || out_last !== (idx == 7)) begin
                    miscompares++;
                    $display("FAIL stall_word%0d: got data=%h last=%b, want data=%h last=%b",
                             idx, out_data, out_last, 8'(8'h40 + idx), (idx == 7));
                end
                idx++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            @(negedge clk);
        end
        vectors++;
        if (idx != 8 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL stall_count: got words=%0d done_pulses=%0d, want 8 and 1", idx, done_cnt);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_ignore_start;
        int idx = 0;
        int done_cnt = 0;
        out_ready = 1'b1;
        pulse_start(8'h80, 9'd16);
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (out_valid) begin
                vectors++;
                if (idx >= 16 || out_data !== 8'(8'h80 + idx) || out_last !== (idx == 15)) begin
                    miscompares++;
                    $display("FAIL ignore_word%0d: got data=%h last=%b, want data=%h last=%b",
                             idx, out_data, out_last, 8'(8'h80 + idx), (idx == 15));
                end
                idx++;
            end
            if (cyc == 5) begin
                start = 1'b1; base_addr = 8'h00; length = 9'd3;
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (idx != 16 || done_cnt != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_count: got words=%0d done_pulses=%0d busy=%b, want 16, 1, 0", idx, done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid;
        int done_cnt = 0;
        out_ready = 1'b1;
        pulse_start(8'h20, 9'd10);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 5) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== 8'(8'h20 + k - 3)) begin
                    miscompares++;
                    $display("FAIL rstmid_word%0d: got valid=%b data=%h, want valid=1 data=%h",
                             k - 3, out_valid, out_data, 8'(8'h20 + k - 3));
                end
            end
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({read_addr, out_valid, out_last, busy, done} !== 12'h000) begin
            miscompares++;
            $display("FAIL rstmid_async: got addr=%h valid=%b last=%b busy=%b done=%b, want all 0",
                     read_addr, out_valid, out_last, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || out_valid || busy) done_cnt++;
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: got %0d active cycles after reset, want 0", done_cnt);
        end
        pulse_start(8'h30, 9'd2);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h30 + k) || out_last !== (k == 1)) begin
                miscompares++;
                $display("FAIL rstmid_fresh%0d: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                         k, out_valid, out_data, out_last, 8'(8'h30 + k), (k == 1));
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_fresh_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst_n     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        #2;
        test_reset;
        test_basic;
        test_wrap;
        test_zero_len;
        test_stall;
        test_ignore_start;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
